// File: rtl/reservation_station_pkg.sv
// Shared widths and decoded-op constants used by the Decoder, Dispatcher, ALU and reservation station.
package reservation_station_pkg;

   localparam int unsigned DEF_DATA_LEN   = 32;
   localparam int unsigned DEF_ROB_ID_LEN = 4;
   localparam int unsigned DEF_OPENUM_LEN = 6;

   typedef enum logic [DEF_OPENUM_LEN-1:0] {
      OP_NOP  = 6'd0,
      OP_ADD  = 6'd1,
      OP_SUB  = 6'd2,
      OP_ADDI = 6'd3,
      OP_AND  = 6'd4,
      OP_OR   = 6'd5,
      OP_XOR  = 6'd6,
      OP_SLL  = 6'd7,
      OP_SRL  = 6'd8,
      OP_SLT  = 6'd9,
      OP_BEQ  = 6'd10,
      OP_BNE  = 6'd11,
      OP_LW   = 6'd12,
      OP_SW   = 6'd13
   } openum_e;

endpackage

// File: rtl/rs_pick.sv
// Lowest-index priority encoder: returns the first set bit of mask and whether any bit was set.
module rs_pick #(
   parameter  int unsigned N     = 2,
   localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     mask,
   output logic [IDX_W-1:0] idx_c,
   output logic             found_c
);

   always_comb begin
      idx_c   = '0;
      found_c = 1'b0;
      for (int i = 0; i < N; i++) begin
         if (mask[i] && !found_c) begin
            found_c = 1'b1;
            idx_c   = IDX_W'(i);
         end
      end
   end

endmodule

// File: rtl/reservation_station.sv
// Multi-CDB reservation station: holds dispatched ops, wakes operands from the result buses
// and issues the lowest-index ready slot to the ALU over a valid/ready handshake.
module reservation_station
   import reservation_station_pkg::*;
#(
   parameter int unsigned ENTRIES    = 16,
   parameter int unsigned CDB_PORTS  = 2,
   parameter int unsigned DATA_LEN   = DEF_DATA_LEN,
   parameter int unsigned ROB_ID_LEN = DEF_ROB_ID_LEN,
   parameter int unsigned OPENUM_LEN = DEF_OPENUM_LEN
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             rollback,
   output logic                             full,
   input  logic                             in_valid,
   input  logic [OPENUM_LEN-1:0]            in_openum,
   input  logic [DATA_LEN-1:0]              in_vj,
   input  logic [DATA_LEN-1:0]              in_vk,
   input  logic                             in_qj_busy,
   input  logic                             in_qk_busy,
   input  logic [ROB_ID_LEN-1:0]            in_qj,
   input  logic [ROB_ID_LEN-1:0]            in_qk,
   input  logic [DATA_LEN-1:0]              in_imm,
   input  logic [DATA_LEN-1:0]              in_pc,
   input  logic [ROB_ID_LEN-1:0]            in_rob_id,
   input  logic [CDB_PORTS-1:0]             cdb_valid,
   input  logic [CDB_PORTS*ROB_ID_LEN-1:0]  cdb_rob_id,
   input  logic [CDB_PORTS*DATA_LEN-1:0]    cdb_value,
   input  logic                             alu_ready,
   output logic                             out_valid,
   output logic [OPENUM_LEN-1:0]            out_openum,
   output logic [DATA_LEN-1:0]              out_vj,
   output logic [DATA_LEN-1:0]              out_vk,
   output logic [DATA_LEN-1:0]              out_imm,
   output logic [DATA_LEN-1:0]              out_pc,
   output logic [ROB_ID_LEN-1:0]            out_rob_id
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);
   localparam int unsigned CNT_W = $clog2(ENTRIES + 1);

   logic [ENTRIES-1:0]    busy, qj_busy, qk_busy;
   logic [OPENUM_LEN-1:0] openum [ENTRIES];
   logic [DATA_LEN-1:0]   vj     [ENTRIES];
   logic [DATA_LEN-1:0]   vk     [ENTRIES];
   logic [DATA_LEN-1:0]   imm    [ENTRIES];
   logic [DATA_LEN-1:0]   pc     [ENTRIES];
   logic [ROB_ID_LEN-1:0] qj     [ENTRIES];
   logic [ROB_ID_LEN-1:0] qk     [ENTRIES];
   logic [ROB_ID_LEN-1:0] rob_id [ENTRIES];
   logic [CNT_W-1:0]      count;

   logic [ENTRIES-1:0]    j_hit, k_hit;
   logic [DATA_LEN-1:0]   j_val [ENTRIES];
   logic [DATA_LEN-1:0]   k_val [ENTRIES];
   logic                  in_j_hit, in_k_hit;
   logic [DATA_LEN-1:0]   in_j_val, in_k_val;
   logic [ENTRIES-1:0]    ready_mask;
   logic [IDX_W-1:0]      free_idx, ready_idx;
   logic                  free_found, ready_found;
   logic                  accept, issue;
   logic [CNT_W-1:0]      count_next;

   // Snoop all broadcast channels for a tag; the lowest-numbered matching channel wins.
   function automatic logic cdb_match(input logic [ROB_ID_LEN-1:0] tag,
                                      output logic [DATA_LEN-1:0] val);
      cdb_match = 1'b0;
      val       = '0;
      for (int i = 0; i < CDB_PORTS; i++) begin
         if (!cdb_match && cdb_valid[i] && (cdb_rob_id[i*ROB_ID_LEN +: ROB_ID_LEN] == tag)) begin
            cdb_match = 1'b1;
            val       = cdb_value[i*DATA_LEN +: DATA_LEN];
         end
      end
   endfunction

   rs_pick #(.N(ENTRIES)) u_free_pick (
      .mask    (~busy),
      .idx_c   (free_idx),
      .found_c (free_found)
   );

   rs_pick #(.N(ENTRIES)) u_ready_pick (
      .mask    (ready_mask),
      .idx_c   (ready_idx),
      .found_c (ready_found)
   );

   always_comb begin
      ready_mask = busy & ~qj_busy & ~qk_busy;
      accept     = in_valid && !full && free_found;
      issue      = (!out_valid || alu_ready) && ready_found;
      count_next = count;
      if (accept && !issue)      count_next = count + CNT_W'(1);
      else if (!accept && issue) count_next = count - CNT_W'(1);
      for (int e = 0; e < ENTRIES; e++) begin
         j_hit[e] = cdb_match(qj[e], j_val[e]);
         k_hit[e] = cdb_match(qk[e], k_val[e]);
      end
      in_j_hit = cdb_match(in_qj, in_j_val);
      in_k_hit = cdb_match(in_qk, in_k_val);
   end

   always_ff @(posedge clk) begin
      if (rst || rollback) begin
         busy       <= '0;
         count      <= '0;
         full       <= 1'b0;
         out_valid  <= 1'b0;
         out_openum <= '0;
         out_vj     <= '0;
         out_vk     <= '0;
         out_imm    <= '0;
         out_pc     <= '0;
         out_rob_id <= '0;
      end else begin
         assert (!(in_valid && full))
            else $warning("reservation_station: dispatch dropped, station full");
         for (int e = 0; e < ENTRIES; e++) begin
            if (busy[e] && qj_busy[e] && j_hit[e]) begin
               vj[e]      <= j_val[e];
               qj_busy[e] <= 1'b0;
            end
            if (busy[e] && qk_busy[e] && k_hit[e]) begin
               vk[e]      <= k_val[e];
               qk_busy[e] <= 1'b0;
            end
         end
         // Dispatch bypass: an operand produced this very cycle is captured as a value.
         if (accept) begin
            busy[free_idx]    <= 1'b1;
            openum[free_idx]  <= in_openum;
            vj[free_idx]      <= (in_qj_busy && in_j_hit) ? in_j_val : in_vj;
            vk[free_idx]      <= (in_qk_busy && in_k_hit) ? in_k_val : in_vk;
            qj_busy[free_idx] <= in_qj_busy && !in_j_hit;
            qk_busy[free_idx] <= in_qk_busy && !in_k_hit;
            qj[free_idx]      <= in_qj;
            qk[free_idx]      <= in_qk;
            imm[free_idx]     <= in_imm;
            pc[free_idx]      <= in_pc;
            rob_id[free_idx]  <= in_rob_id;
         end
         if (issue) begin
            busy[ready_idx] <= 1'b0;
            out_valid       <= 1'b1;
            out_openum      <= openum[ready_idx];
            out_vj          <= vj[ready_idx];
            out_vk          <= vk[ready_idx];
            out_imm         <= imm[ready_idx];
            out_pc          <= pc[ready_idx];
            out_rob_id      <= rob_id[ready_idx];
         end else if (alu_ready) begin
            out_valid <= 1'b0;
         end
         count <= count_next;
         full  <= (count_next == CNT_W'(ENTRIES));
      end
   end

endmodule
